// File: rtl/ex_div_seq.sv
// Multi-cycle radix-2 restoring divider for the EX stage; stalls the pipeline until {remainder, quotient} is ready.
// Define DIV_SIGNED_EN to honour signed_i (div); otherwise every request is treated as divu.
module ex_div_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stallreq_o
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BYZERO, ON, END} state_t;

  state_t             state_reg, state_next;
  logic [CW-1:0]      cnt_reg;
  logic [WIDTH:0]     rem_reg;
  logic [WIDTH-1:0]   dvd_reg;
  logic [WIDTH-1:0]   dsr_reg;
  logic [2*WIDTH-1:0] result_reg;

  logic               req_ok;
  logic               div_zero;
  logic               step_done;
  logic [WIDTH-1:0]   dvd_load;
  logic [WIDTH-1:0]   dsr_load;
  logic [WIDTH:0]     rem_shift;
  logic               rem_ge;
  logic [WIDTH-1:0]   quot_final;
  logic [WIDTH-1:0]   rem_final;
  logic               unused_bits;

  assign req_ok    = start_i && !annul_i;
  assign div_zero  = (opdata2_i == '0);
  assign step_done = (cnt_reg == CW'(WIDTH));

  // The partial remainder is always below the divisor, so its top bit is only needed after the shift.
  assign rem_shift = {rem_reg[WIDTH-1:0], dvd_reg[WIDTH-1]};
  assign rem_ge    = (rem_shift >= {1'b0, dsr_reg});

`ifdef DIV_SIGNED_EN
  logic neg_q_reg, neg_r_reg;
  logic a_neg, b_neg;

  assign a_neg      = signed_i && opdata1_i[WIDTH-1];
  assign b_neg      = signed_i && opdata2_i[WIDTH-1];
  assign dvd_load   = a_neg ? -opdata1_i : opdata1_i;
  assign dsr_load   = b_neg ? -opdata2_i : opdata2_i;
  assign quot_final = neg_q_reg ? -dvd_reg : dvd_reg;
  assign rem_final  = neg_r_reg ? -rem_reg[WIDTH-1:0] : rem_reg[WIDTH-1:0];
  assign unused_bits = rem_reg[WIDTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      neg_q_reg <= 1'b0;
      neg_r_reg <= 1'b0;
    end else if (state_reg == IDLE && req_ok && !div_zero) begin
      neg_q_reg <= a_neg ^ b_neg;
      neg_r_reg <= a_neg;
    end
  end
`else
  assign dvd_load    = opdata1_i;
  assign dsr_load    = opdata2_i;
  assign quot_final  = dvd_reg;
  assign rem_final   = rem_reg[WIDTH-1:0];
  assign unused_bits = rem_reg[WIDTH] ^ signed_i;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (req_ok) begin
          state_next = div_zero ? BYZERO : ON;
        end
      end
      BYZERO: begin
        state_next = annul_i ? IDLE : END;
      end
      ON: begin
        if (annul_i) begin
          state_next = IDLE;
        end else if (step_done) begin
          state_next = END;
        end
      end
      END: begin
        if (!start_i || annul_i) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // An annulled division leaves result_reg untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg    <= '0;
      rem_reg    <= '0;
      dvd_reg    <= '0;
      dsr_reg    <= '0;
      result_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_ok && !div_zero) begin
            cnt_reg <= '0;
            rem_reg <= '0;
            dvd_reg <= dvd_load;
            dsr_reg <= dsr_load;
          end
        end
        BYZERO: begin
          if (!annul_i) begin
            result_reg <= '0;
          end
        end
        ON: begin
          if (!annul_i) begin
            if (!step_done) begin
              rem_reg <= rem_ge ? (rem_shift - {1'b0, dsr_reg}) : rem_shift;
              dvd_reg <= {dvd_reg[WIDTH-2:0], rem_ge};
              cnt_reg <= cnt_reg + 1'b1;
            end else begin
              result_reg <= {rem_final, quot_final};
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign result_o   = result_reg;
  assign ready_o    = (state_reg == END);
  assign stallreq_o = start_i && !ready_o && !annul_i;

endmodule

// File: doc/ex_div_seq.md
# ex_div_seq

Multi-cycle divide sequencer for the EX stage. It accepts a divide request from the execute logic and runs a radix-2 restoring division, one quotient bit per clock. While the division is running it requests a pipeline stall, then presents the `{remainder, quotient}` result for write-back into HI/LO. It is the single shared divide resource and holds the EX stage until the result is valid.

## Interface

**Parameters**
- `WIDTH`, default 32: operand width; the result is `2*WIDTH` bits.

**Ports**
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: reset, asynchronous, active-low (0 = reset).
- `start_i`  in  1: divide request; held high by EX until `ready_o` is seen.
- `annul_i`  in  1: cancel the current or pending division (flush/exception).
- `signed_i`  in  1: signed divide (div) when 1, unsigned (divu) when 0.
- `opdata1_i`  in  WIDTH: dividend, sampled on the start edge only.
- `opdata2_i`  in  WIDTH: divisor, sampled on the start edge only.
- `result_o`  out  2*WIDTH: `{remainder, quotient}`.
- `ready_o`  out  1: result valid.
- `stallreq_o`  out  1: stall request to the pipeline controller.

## Operation

**FSM states:** IDLE, BYZERO, ON, END.

- **IDLE**
  - If `start_i & !annul_i` and the divisor is 0: go to BYZERO.
  - If `start_i & !annul_i` and the divisor is nonzero: latch the operands (after sign conversion), clear the step counter `cnt` (6 bits), and go to ON.
  - Otherwise stay in IDLE.
- **BYZERO**
  - Next edge: `result_o` is set to 0 and the FSM goes to END.
- **ON**
  - While `cnt != WIDTH`, each edge does one step:
    - Shift `{partial_rem, dividend_msb}` left by one.
    - If `partial_rem >= divisor`, subtract the divisor and set the quotient bit to 1; otherwise set it to 0.
    - Increment `cnt`.
  - When `cnt == WIDTH`: apply the sign fix-up, load `result_o`, and go to END.
  - The partial remainder is `WIDTH+1` bits so the compare cannot overflow.
- **END**
  - `ready_o = 1` and `result_o` is held.
  - Go to IDLE on the first edge where `start_i == 0` or `annul_i == 1`.
- **`annul_i`** in BYZERO or ON: go to IDLE on the next edge. `ready_o` is never raised and `result_o` keeps its previous value.
- **`stallreq_o`** is combinational: `start_i & !ready_o & !annul_i`.
- **Reset:** `rst = 0` at any time, including mid-division, forces IDLE and `cnt = 0` immediately. `result_o = 0`, `ready_o = 0`, `stallreq_o` follows its equation (0 once `start_i` is low).
- **Arithmetic corner cases:**
  - Divide by zero gives quotient = 0 and remainder = 0.
  - The most-negative value divided by −1 (signed) gives quotient = `0x80000000`, remainder = 0 (natural wrap, no trap).

## Timing

- **Start edge:** `start_i` is high in cycle 0 and sampled at the end of cycle 0 (edge E0).
- **Nonzero divisor:**
  - ON covers E1..E33; E1..E32 are the 32 steps and E33 does the fix-up.
  - `ready_o` is high from cycle 34, so latency is 34 cycles for `WIDTH = 32` (`WIDTH + 2` in general).
  - `stallreq_o` is high in cycles 0–33 and low in cycle 34.
- **Zero divisor:** BYZERO at E0, END at E1, `ready_o` high from cycle 2.
- **No back-to-back start:** `start_i` must be low for at least one cycle before a new request. `start_i` held high in END never restarts the divider.
- **Operand changes:** changes to `opdata*_i` or `signed_i` after the start edge are ignored.

## Configuration

- **`DIV_SIGNED_EN` defined:** `signed_i` is honoured.
  - Negative operands are negated to absolute values when loaded.
  - The quotient is negated if the operand signs differ.
  - The remainder takes the sign of the dividend.
- **`DIV_SIGNED_EN` undefined:** `signed_i` is ignored and every operation is unsigned. The sign logic and negators are not synthesised.

## Test plan

1. **Unsigned divide:** 100 / 7 with `signed_i = 0`, start in cycle 0 -> `stallreq_o` high in cycles 0–33; from cycle 34 `ready_o = 1` and `result_o = 64'h00000002_0000000E`.
2. **Divide by zero:** 5 / 0 -> `ready_o` high from cycle 2, `result_o = 0`; `stallreq_o` high in cycles 0–1 only.
3. **Signed divide, `DIV_SIGNED_EN` defined:** `0xFFFFFFF9` / 2 with `signed_i = 1` -> `result_o = 64'hFFFFFFFF_FFFFFFFD`. Same stimulus with the macro undefined -> `64'h00000001_7FFFFFFC`.
4. **Annul then restart:** `annul_i` pulsed in cycle 10 of a division -> `ready_o` stays 0 and `stallreq_o` drops in cycle 10. Then start `0xFFFFFFFF` / 1 -> `result_o = 64'h00000000_FFFFFFFF` 34 cycles later.
5. **Reset mid-division:** `rst` driven to 0 asynchronously in cycle 20 -> `ready_o` and `result_o` are 0 immediately. After `rst` returns to 1 with `start_i` low, the FSM is in IDLE and `stallreq_o = 0`.
6. **Start held in END:** `start_i` kept high for 5 cycles in END -> `ready_o` stays 1, `result_o` is stable, no restart. Drop `start_i` -> `ready_o = 0` after the next edge, and a fresh start runs a full 34-cycle division.
